// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the regfile write port.
// The master side is the requesters plus regfile; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            p0_valid;
    logic            p0_ready;
    logic [AW-1:0]   p0_rd;
    logic [XLEN-1:0] p0_data;

    logic            p1_valid;
    logic            p1_ready;
    logic [AW-1:0]   p1_rd;
    logic [XLEN-1:0] p1_data;

    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] w_data;
    logic            w_en;
    logic            pend_valid;
    logic [AW-1:0]   pend_rd;
    logic            starve_hit;

    modport master (
        output p0_valid, p0_rd, p0_data,
        output p1_valid, p1_rd, p1_data,
        input  p0_ready, p1_ready,
        input  rd_addr, w_data, w_en, pend_valid, pend_rd, starve_hit
    );

    modport slave (
        input  p0_valid, p0_rd, p0_data,
        input  p1_valid, p1_rd, p1_data,
        output p0_ready, p1_ready,
        output rd_addr, w_data, w_en, pend_valid, pend_rd, starve_hit
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between the ALU (port 0) and load unit (port 1).
// Loads win by default; an ALU request refused MAX_WAIT cycles in a row is forced through.
module regfile_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]      wait_cnt;
    logic            force0;
    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    logic [AW-1:0]   rd_addr_q;
    logic [XLEN-1:0] w_data_q;
    logic            w_en_q;
    logic            starve_q;

    // Grants see only valids and the wait counter, never rd/data, and drop while reset is high.
    assign force0 = bus.p0_valid && (wait_cnt == MAX_WAIT_C);
    assign grant1 = !reset && bus.p1_valid && !force0;
    assign grant0 = !reset && bus.p0_valid && !grant1;
    assign xfer   = grant0 || grant1;

    assign bus.p0_ready = grant0;
    assign bus.p1_ready = grant1;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_rd   = bus.p0_rd;
        sel_data = bus.p0_data;
        if (grant1) begin
            sel_rd   = bus.p1_rd;
            sel_data = bus.p1_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            rd_addr_q <= '0;
            w_data_q  <= '0;
            w_en_q    <= 1'b0;
            starve_q  <= 1'b0;
        end else begin
            if (bus.p0_valid && !grant0) begin
                wait_cnt <= (wait_cnt == MAX_WAIT_C) ? wait_cnt : wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

            // A grant to x0 is consumed but never enables the write.
            w_en_q <= xfer && (sel_rd != '0);
            if (xfer) begin
                rd_addr_q <= sel_rd;
                w_data_q  <= sel_data;
            end

            starve_q <= grant0 && force0 && bus.p1_valid;
        end
    end

    assign bus.rd_addr    = rd_addr_q;
    assign bus.w_data     = w_data_q;
    assign bus.w_en       = w_en_q;
    assign bus.pend_valid = w_en_q;
    assign bus.pend_rd    = rd_addr_q;
    assign bus.starve_hit = starve_q;
endmodule
